// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_fwd_unit: operand forwarding select and load-use stall detection.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module hazard_fwd_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             id_valid,
    input  logic [4:0]       id_rj,
    input  logic [4:0]       id_rk,
    input  logic             id_rj_used,
    input  logic             id_rk_used,
    input  logic [4:0]       id_dest,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             pipe_hold,
    input  logic             flush,
    input  logic             stall_cnt_clr,
    output logic [2:0]       fwd_rj_ctrl,
    output logic [2:0]       fwd_rk_ctrl,
    output logic             ld_use_stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] C_FWD_GR      = 3'd0;
    localparam logic [2:0] C_FWD_EX      = 3'd1;
    localparam logic [2:0] C_FWD_MM1     = 3'd2;
    localparam logic [2:0] C_FWD_MM2_REG = 3'd3;
    localparam logic [2:0] C_FWD_MM2_MEM = 3'd4;
    localparam logic [2:0] C_FWD_WB      = 3'd5;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] dest;
        logic       is_load;
    } tag_t;

    tag_t             r_ex;
    tag_t             r_mm1;
    tag_t             r_mm2;
    tag_t             r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_rj_ld_hit;
    logic             w_rk_ld_hit;
    logic             w_stall;
    logic [2:0]       w_rj_sel;
    logic [2:0]       w_rk_sel;
    tag_t             w_ex_next;

    function automatic logic tag_hit(input tag_t t, input logic [4:0] s, input logic used);
        return t.valid && t.we && (t.dest != 5'd0) && (t.dest == s) && used;
    endfunction

    // Oldest stage evaluated first so younger matches override it.
    function automatic logic [2:0] src_sel(input logic [4:0] s, input logic used,
                                           input tag_t ex, input tag_t mm1,
                                           input tag_t mm2, input tag_t wb);
        logic [2:0] sel;
        sel = C_FWD_GR;
        if (tag_hit(wb, s, used))
            sel = C_FWD_WB;
        if (tag_hit(mm2, s, used))
            sel = mm2.is_load ? C_FWD_MM2_MEM : C_FWD_MM2_REG;
        if (tag_hit(mm1, s, used))
            sel = mm1.is_load ? C_FWD_GR : C_FWD_MM1;
        if (tag_hit(ex, s, used))
            sel = ex.is_load ? C_FWD_GR : C_FWD_EX;
        return sel;
    endfunction

    assign w_rj_ld_hit = (tag_hit(r_ex, id_rj, id_rj_used) && r_ex.is_load) ||
                         (tag_hit(r_mm1, id_rj, id_rj_used) && r_mm1.is_load);
    assign w_rk_ld_hit = (tag_hit(r_ex, id_rk, id_rk_used) && r_ex.is_load) ||
                         (tag_hit(r_mm1, id_rk, id_rk_used) && r_mm1.is_load);
    assign w_stall     = id_valid && !flush && (w_rj_ld_hit || w_rk_ld_hit);

    assign w_rj_sel = src_sel(id_rj, id_rj_used, r_ex, r_mm1, r_mm2, r_wb);
    assign w_rk_sel = src_sel(id_rk, id_rk_used, r_ex, r_mm1, r_mm2, r_wb);

    assign fwd_rj_ctrl  = w_stall ? C_FWD_GR : w_rj_sel;
    assign fwd_rk_ctrl  = w_stall ? C_FWD_GR : w_rk_sel;
    assign ld_use_stall = w_stall;
    assign stall_cnt    = r_stall_cnt;

    always_comb begin
        w_ex_next = '0;
        if (id_valid && !w_stall && !flush) begin
            w_ex_next.valid   = 1'b1;
            w_ex_next.we      = id_we;
            w_ex_next.dest    = id_dest;
            w_ex_next.is_load = id_is_load;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ex  <= '0;
            r_mm1 <= '0;
            r_mm2 <= '0;
            r_wb  <= '0;
        end else if (!pipe_hold) begin
            r_wb  <= r_mm2;
            r_mm2 <= r_mm1;
            r_mm1 <= r_ex;
            r_ex  <= w_ex_next;
        end
    end

    // Clear has priority; increment saturates at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_stall_cnt <= '0;
        else if (stall_cnt_clr)
            r_stall_cnt <= '0;
        else if (w_stall && !pipe_hold && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// Scoreboard bench for hazard_fwd_unit: a 32-bit counter instance plus a 3-bit one
// sharing the same stimulus so counter saturation is reachable.
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid, id_rj_used, id_rk_used, id_we, id_is_load;
    logic [4:0]  id_rj, id_rk, id_dest;
    logic        pipe_hold, flush, stall_cnt_clr;
    logic [2:0]  fwd_rj, fwd_rk, s_fwd_rj, s_fwd_rk;
    logic        stall, s_stall;
    logic [31:0] cnt;
    logic [2:0]  s_cnt;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .id_valid(id_valid),
        .id_rj(id_rj), .id_rk(id_rk), .id_rj_used(id_rj_used), .id_rk_used(id_rk_used),
        .id_dest(id_dest), .id_we(id_we), .id_is_load(id_is_load),
        .pipe_hold(pipe_hold), .flush(flush), .stall_cnt_clr(stall_cnt_clr),
        .fwd_rj_ctrl(fwd_rj), .fwd_rk_ctrl(fwd_rk), .ld_use_stall(stall), .stall_cnt(cnt)
    );

    hazard_fwd_unit #(.CNT_W(3)) dut_s (
        .clk(clk), .resetn(resetn), .id_valid(id_valid),
        .id_rj(id_rj), .id_rk(id_rk), .id_rj_used(id_rj_used), .id_rk_used(id_rk_used),
        .id_dest(id_dest), .id_we(id_we), .id_is_load(id_is_load),
        .pipe_hold(pipe_hold), .flush(flush), .stall_cnt_clr(stall_cnt_clr),
        .fwd_rj_ctrl(s_fwd_rj), .fwd_rk_ctrl(s_fwd_rk), .ld_use_stall(s_stall), .stall_cnt(s_cnt)
    );

    typedef struct {
        string       name;
        logic [2:0]  rj;
        logic [2:0]  rk;
        logic        st;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, fld, act, want);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "fwd_rj", {29'd0, fwd_rj}, {29'd0, e.rj});
                cmp(e.name, "fwd_rk", {29'd0, fwd_rk}, {29'd0, e.rk});
                cmp(e.name, "stall", {31'd0, stall}, {31'd0, e.st});
                cmp(e.name, "cnt32", cnt, e.cnt);
                cmp(e.name, "cnt3", {29'd0, s_cnt}, (e.cnt > 32'd7) ? 32'd7 : e.cnt);
            end
        end
    end

    task automatic expect_out(input string nm, input logic [2:0] rj, input logic [2:0] rk,
                              input logic st, input logic [31:0] c);
        exp_t e;
        e.name = nm; e.rj = rj; e.rk = rk; e.st = st; e.cnt = c;
        q.push_back(e);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rj, input logic rju,
                          input logic [4:0] rk, input logic rku,
                          input logic [4:0] d, input logic we, input logic ld);
        id_valid = v; id_rj = rj; id_rj_used = rju; id_rk = rk; id_rk_used = rku;
        id_dest = d; id_we = we; id_is_load = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        pipe_hold = 1'b0; flush = 1'b0; stall_cnt_clr = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; pipe_hold = 1'b0; flush = 1'b0; stall_cnt_clr = 1'b0;
        set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        expect_out("reset", 3'd0, 3'd0, 1'b0, 32'd0);
        tick();
        resetn = 1'b1;
        idle(2);

        // EX then MM1 / MM2 / WB forwarding, rj and rk independent
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        expect_out("ex_setup", 3'd0, 3'd0, 1'b0, 32'd0); tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0);
        expect_out("fwd_ex", 3'd1, 3'd0, 1'b0, 32'd0); tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("fwd_mm1", 3'd2, 3'd1, 1'b0, 32'd0); tick();
        expect_out("fwd_mm2reg", 3'd3, 3'd2, 1'b0, 32'd0); tick();
        expect_out("fwd_wb", 3'd5, 3'd3, 1'b0, 32'd0); tick();
        expect_out("fwd_wb2", 3'd0, 3'd5, 1'b0, 32'd0); tick();
        idle(4);

        // load-use: two stall cycles then MM2_MEM
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        expect_out("ld_issue", 3'd0, 3'd0, 1'b0, 32'd0); tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        expect_out("lu_stall1", 3'd0, 3'd0, 1'b1, 32'd0); tick();
        expect_out("lu_stall2", 3'd0, 3'd0, 1'b1, 32'd1); tick();
        expect_out("lu_mem", 3'd4, 3'd0, 1'b0, 32'd2); tick();
        idle(4);

        // youngest wins (EX over WB); r0 never forwarded
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        expect_out("r3_a", 3'd0, 3'd0, 1'b0, 32'd2); tick();
        idle(2);
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        expect_out("young_ex", 3'd1, 3'd0, 1'b0, 32'd2); tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("r0_gr", 3'd0, 3'd2, 1'b0, 32'd2); tick();
        idle(4);

        // pipe_hold freezes tags
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0); tick();
        idle(1);
        pipe_hold = 1'b1;
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        expect_out("hold1", 3'd2, 3'd0, 1'b0, 32'd2); tick();
        expect_out("hold2", 3'd2, 3'd0, 1'b0, 32'd2); tick();
        expect_out("hold3", 3'd2, 3'd0, 1'b0, 32'd2); tick();
        pipe_hold = 1'b0;
        expect_out("hold_rel", 3'd2, 3'd0, 1'b0, 32'd2); tick();
        set_id(1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("post_hold", 3'd3, 3'd1, 1'b0, 32'd2); tick();
        idle(4);

        // stall during hold does not count
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1); tick();
        pipe_hold = 1'b1;
        set_id(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        expect_out("hold_stall1", 3'd0, 3'd0, 1'b1, 32'd2); tick();
        expect_out("hold_stall2", 3'd0, 3'd0, 1'b1, 32'd2); tick();
        pipe_hold = 1'b0;
        expect_out("stall_a", 3'd0, 3'd0, 1'b1, 32'd2); tick();
        expect_out("stall_b", 3'd0, 3'd0, 1'b1, 32'd3); tick();
        expect_out("stall_mem", 3'd4, 3'd0, 1'b0, 32'd4); tick();
        idle(4);

        // flush kills the ID writer and masks the stall
        flush = 1'b1;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        expect_out("flush_kill", 3'd0, 3'd0, 1'b0, 32'd4); tick();
        flush = 1'b0;
        set_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("flush_gone", 3'd0, 3'd0, 1'b0, 32'd4); tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1); tick();
        flush = 1'b1;
        set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("flush_nostall", 3'd0, 3'd0, 1'b0, 32'd4); tick();
        idle(4);

        // chained loads: drives the 3-bit counter into saturation, then clear
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1); tick();
        set_id(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1);
        expect_out("sat_a1", 3'd0, 3'd0, 1'b1, 32'd4); tick();
        expect_out("sat_a2", 3'd0, 3'd0, 1'b1, 32'd5); tick();
        expect_out("sat_a3", 3'd4, 3'd0, 1'b0, 32'd6); tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 5'd15, 1'b1, 1'b1);
        expect_out("sat_b1", 3'd0, 3'd0, 1'b1, 32'd6); tick();
        expect_out("sat_b2", 3'd0, 3'd0, 1'b1, 32'd7); tick();
        expect_out("sat_b3", 3'd0, 3'd4, 1'b0, 32'd8); tick();
        set_id(1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        stall_cnt_clr = 1'b1;
        expect_out("clr_a", 3'd0, 3'd0, 1'b1, 32'd8); tick();
        stall_cnt_clr = 1'b0;
        expect_out("clr_b", 3'd0, 3'd0, 1'b1, 32'd0); tick();
        expect_out("clr_c", 3'd4, 3'd0, 1'b0, 32'd1); tick();
        idle(4);

        // asynchronous reset in the middle of a stall
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd16, 1'b1, 1'b1); tick();
        set_id(1'b1, 5'd16, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("rst_pre", 3'd0, 3'd0, 1'b1, 32'd1);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        expect_out("rst_mid", 3'd0, 3'd0, 1'b0, 32'd0); tick();
        resetn = 1'b1;
        expect_out("rst_resume", 3'd0, 3'd0, 1'b0, 32'd0); tick();
        idle(2);

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
